// File: rtl/wb_regfile_if.sv
// Writeback / register-file bus: MEM/WB inputs, decode read ports, debug port, retire count.
interface wb_regfile_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] WB_pc4;
    logic [XLEN-1:0] WB_alu_result;
    logic [XLEN-1:0] WB_load_data;
    logic [4:0]      WB_rd;
    logic            WB_RegWrite;
    logic [1:0]      WB_ResultSrc;
    logic            WB_valid;
    logic [4:0]      ID_rs1;
    logic [4:0]      ID_rs2;
    logic [XLEN-1:0] ID_rs1_data;
    logic [XLEN-1:0] ID_rs2_data;
    logic [XLEN-1:0] wb_result;
    logic            wb_write_en;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [63:0]     instret;

    modport master (
        output WB_pc4, WB_alu_result, WB_load_data, WB_rd, WB_RegWrite,
               WB_ResultSrc, WB_valid, ID_rs1, ID_rs2, dbg_addr,
        input  ID_rs1_data, ID_rs2_data, wb_result, wb_write_en, dbg_data, instret
    );

    modport slave (
        input  WB_pc4, WB_alu_result, WB_load_data, WB_rd, WB_RegWrite,
               WB_ResultSrc, WB_valid, ID_rs1, ID_rs2, dbg_addr,
        output ID_rs1_data, ID_rs2_data, wb_result, wb_write_en, dbg_data, instret
    );
endinterface

// File: rtl/wb_regfile.sv
// RV32I writeback stage: result select, 32x32 register file with write-through
// bypass on the decode read ports, committed-state debug port, 64-bit retire counter.
module wb_regfile #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [63:0]     instret_q;
    logic [63:0]     instret_d;
    logic [XLEN-1:0] result;
    logic            write_en;

    // Writeback result select; the reserved code 11 falls back to the ALU result.
    always_comb begin
        case (bus.WB_ResultSrc)
            2'b01:   result = bus.WB_load_data;
            2'b10:   result = bus.WB_pc4;
            default: result = bus.WB_alu_result;
        endcase
        write_en = bus.WB_RegWrite && bus.WB_valid && (bus.WB_rd != 5'd0);
    end

    assign bus.wb_result   = result;
    assign bus.wb_write_en = write_en;

    // Next register-file and counter state; x0 is excluded by write_en.
    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[bus.WB_rd] = result;
        end
        instret_d = bus.WB_valid ? instret_q + 64'd1 : instret_q;
    end

    // State registers; reset clears everything and drops any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '{default: '0};
            instret_q <= 64'd0;
        end else begin
            regs_q    <= regs_d;
            instret_q <= instret_d;
        end
    end

    // Decode read ports bypass the value being committed this cycle; debug sees committed state only.
    always_comb begin
        bus.ID_rs1_data = '0;
        bus.ID_rs2_data = '0;
        bus.dbg_data    = '0;
        if (bus.ID_rs1 != 5'd0) begin
            bus.ID_rs1_data = (write_en && bus.ID_rs1 == bus.WB_rd) ? result : regs_q[bus.ID_rs1];
        end
        if (bus.ID_rs2 != 5'd0) begin
            bus.ID_rs2_data = (write_en && bus.ID_rs2 == bus.WB_rd) ? result : regs_q[bus.ID_rs2];
        end
        if (bus.dbg_addr != 5'd0) begin
            bus.dbg_data = regs_q[bus.dbg_addr];
        end
    end

    assign bus.instret = instret_q;
endmodule
